// File: rtl/mult_accumulator.sv
// ============================================================================
// mult_accumulator
// ----------------------------------------------------------------------------
// Streaming accumulator for the output of the combinational multipliers.
// It sums Count consecutive products, which turns the stateless multiplier
// datapath into a dot-product / MAC stage.
//
// Products arrive one per valid/ready handshake. When the Count-th product is
// accepted, the total is written into a result register and the block moves
// to Hold. In Hold it presents the result on a valid/ready output until the
// consumer takes it. No new products are accepted while in Hold.
//
// Parameters:
//   Width     - product width in bits (multiplier output width)
//   Count     - number of products summed per result (>= 1)
//   AccWidth  - derived result width, wide enough that the sum never wraps
//   CntWidth  - derived width of the beat counter (at least 1)
//
// Ports:
//   clk_i         in   single clock, all state updates on the rising edge
//   rst_ni        in   asynchronous active-low reset
//   clear_i       in   synchronous abort of the current accumulation/result
//   in_valid_i    in   product on in_data_i is valid
//   in_ready_o    out  block can accept a product this cycle (Accum state)
//   in_data_i     in   unsigned product, Width bits
//   out_valid_o   out  result on out_data_o is valid (Hold state)
//   out_ready_i   in   consumer takes the result this cycle
//   out_data_o    out  unsigned sum of Count products, AccWidth bits
//   beat_count_o  out  products accepted so far in the current accumulation
//
// Both handshake outputs are decoded from the registered state only, so no
// combinational path runs from any input to any output.
// ============================================================================
module mult_accumulator #(
    parameter  int Width    = 8,
    parameter  int Count    = 4,
    localparam int AccWidth = (Count > 1) ? Width + $clog2(Count) : Width,
    localparam int CntWidth = (Count > 1) ? $clog2(Count) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [Width-1:0]    in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [AccWidth-1:0] out_data_o,
    output logic [CntWidth-1:0] beat_count_o
);

    typedef enum logic {
        Accum = 1'b0,
        Hold  = 1'b1
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [AccWidth-1:0]   acc_q;
    logic [AccWidth-1:0]   result_q;
    logic [CntWidth-1:0]   beat_count_q;

    logic                  accept;
    logic                  last_beat;
    logic [AccWidth-1:0]   acc_sum;

    // A beat is taken only in Accum. A simultaneous clear drops that beat,
    // because clear has priority over every other event.
    assign accept    = (state_q == Accum) && in_valid_i && !clear_i;

    // With Count == 1 the counter is a single bit that stays at 0, so every
    // accepted beat is also the last one.
    assign last_beat = (beat_count_q == CntWidth'(Count - 1));

    // The product is zero-extended into the wider accumulator domain.
    assign acc_sum   = acc_q + AccWidth'(in_data_i);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Accum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Clear forces Accum from either state, which discards
    // a held result without any output handshake.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = Accum;
        end else begin
            case (state_q)
                Accum: begin
                    if (accept && last_beat) begin
                        state_d = Hold;
                    end
                end
                Hold: begin
                    if (out_ready_i) begin
                        state_d = Accum;
                    end
                end
                default: begin
                    state_d = Accum;
                end
            endcase
        end
    end

    // Output decode from the registered state only.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            Accum:   in_ready_o  = 1'b1;
            Hold:    out_valid_o = 1'b1;
            default: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b0;
            end
        endcase
    end

    // Accumulator and beat counter. On the final beat the running sum
    // restarts from zero right away, so the next group can start as soon
    // as Hold is left.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            beat_count_q <= '0;
        end else if (clear_i) begin
            acc_q        <= '0;
            beat_count_q <= '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_q        <= '0;
                beat_count_q <= '0;
            end else begin
                acc_q        <= acc_sum;
                beat_count_q <= beat_count_q + CntWidth'(1);
            end
        end
    end

    // Result register. It is written only on the final beat. Clear leaves it
    // untouched, so out_data_o keeps showing the last completed sum even
    // after that sum has been discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
        end else if (accept && last_beat) begin
            result_q <= acc_sum;
        end
    end

    assign out_data_o   = result_q;
    assign beat_count_o = beat_count_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// ============================================================================
// tb_mult_accumulator
// ----------------------------------------------------------------------------
// Self-checking bench for mult_accumulator. The main instance uses Count = 4.
// A second instance uses Count = 1 to cover the single-beat case.
//
// Each group of products pushes its expected sum onto a scoreboard queue. The
// sum is popped when the consumer takes the result, or when clear / reset
// discards it. A small behavioural model tracks the handshake state, the
// partial sum and the beat count, so that every cycle the handshake outputs,
// the beat counter and the result register can be compared against it.
// ============================================================================
module tb_mult_accumulator;

    localparam int TbWidth = 8;
    localparam int TbCount = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic [1:0] beat_count;

    logic       clear_one;
    logic       in_valid_one;
    logic [7:0] in_data_one;
    logic       out_ready_one;
    logic       in_ready_one;
    logic       out_valid_one;
    logic [7:0] out_data_one;
    logic [0:0] beat_count_one;

    int test_count = 0;
    int fail_count = 0;

    int scoreboard[$];
    bit m_hold;
    int m_acc;
    int m_cnt;
    int m_result;

    always #5 clk = ~clk;

    mult_accumulator #(.Width(TbWidth), .Count(TbCount)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .beat_count_o (beat_count)
    );

    mult_accumulator #(.Width(TbWidth), .Count(1)) u_dut_one (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear_one),
        .in_valid_i   (in_valid_one),
        .in_ready_o   (in_ready_one),
        .in_data_i    (in_data_one),
        .out_valid_o  (out_valid_one),
        .out_ready_i  (out_ready_one),
        .out_data_o   (out_data_one),
        .beat_count_o (beat_count_one)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive the inputs, check the outputs at the falling
    // edge, then advance the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        checkOutput("in_ready", 32'(in_ready), 32'(!m_hold));
        checkOutput("out_valid", 32'(out_valid), 32'(m_hold));
        checkOutput("beat_count", 32'(beat_count), m_cnt);
        checkOutput("out_data", 32'(out_data), m_result);
        if (m_hold) begin
            checkOutput("sb_depth", scoreboard.size(), 1);
            if (scoreboard.size() > 0) begin
                checkOutput("sb_result", 32'(out_data), scoreboard[0]);
            end
        end
        @(posedge clk);
        if (clr) begin
            if (m_hold && scoreboard.size() > 0) begin
                void'(scoreboard.pop_front());
            end
            m_hold = 1'b0;
            m_acc  = 0;
            m_cnt  = 0;
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                if (scoreboard.size() > 0) begin
                    void'(scoreboard.pop_front());
                end
            end
        end else if (v) begin
            if (m_cnt == TbCount - 1) begin
                m_result = m_acc + int'(d);
                m_hold   = 1'b1;
                m_acc    = 0;
                m_cnt    = 0;
            end else begin
                m_acc = m_acc + int'(d);
                m_cnt = m_cnt + 1;
            end
        end
        #1;
    endtask

    task automatic sendGroup(input int a, input int b, input int c, input int d,
                             input int expected);
        scoreboard.push_back(expected);
        applyStimulus(1'b1, 8'(a), 1'b1, 1'b0);
        applyStimulus(1'b1, 8'(b), 1'b1, 1'b0);
        applyStimulus(1'b1, 8'(c), 1'b1, 1'b0);
        applyStimulus(1'b1, 8'(d), 1'b1, 1'b0);
    endtask

    // Pulse reset between clock edges and confirm the outputs clear without
    // waiting for a clock.
    task automatic resetAsync();
        in_valid = 1'b0;
        clear    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_beat_count", 32'(beat_count), 0);
        m_hold   = 1'b0;
        m_acc    = 0;
        m_cnt    = 0;
        m_result = 0;
        scoreboard.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic checkSingle(input logic exp_valid, input int exp_data);
        @(negedge clk);
        checkOutput("one_out_valid", 32'(out_valid_one), 32'(exp_valid));
        checkOutput("one_in_ready", 32'(in_ready_one), 32'(!exp_valid));
        checkOutput("one_out_data", 32'(out_data_one), exp_data);
        checkOutput("one_beat_count", 32'(beat_count_one), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b0;
        clear_one     = 1'b0;
        in_valid_one  = 1'b0;
        in_data_one   = '0;
        out_ready_one = 1'b0;
        m_hold        = 1'b0;
        m_acc         = 0;
        m_cnt         = 0;
        m_result      = 0;

        #2;
        checkOutput("init_in_ready", 32'(in_ready), 1);
        checkOutput("init_out_valid", 32'(out_valid), 0);
        checkOutput("init_out_data", 32'(out_data), 0);
        checkOutput("init_beat_count", 32'(beat_count), 0);
        checkOutput("init_one_out_data", 32'(out_data_one), 0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum; result is visible for exactly one cycle.
        sendGroup(14, 78, 70, 0, 162);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Maximum values, then a group that proves acc restarted from zero.
        sendGroup(255, 255, 255, 255, 1020);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        sendGroup(0, 0, 0, 5, 5);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Gaps in in_valid between beats leave the partial sum intact.
        scoreboard.push_back(60);
        applyStimulus(1'b1, 8'd10, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd77, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd20, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd55, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd30, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Backpressure: the held result stays put and the 99s are refused.
        sendGroup(100, 50, 45, 30, 225);
        repeat (5) applyStimulus(1'b1, 8'd99, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'd99, 1'b1, 1'b0);
        sendGroup(10, 20, 30, 40, 100);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Clear mid-group drops the beat presented alongside it.
        applyStimulus(1'b1, 8'd11, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd13, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
        sendGroup(1, 2, 3, 4, 10);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Clear in Hold discards the result; the result register keeps 50.
        sendGroup(5, 10, 15, 20, 50);
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b1);
        sendGroup(1, 1, 1, 1, 4);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Async reset after two beats.
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
        resetAsync();
        sendGroup(2, 2, 2, 2, 8);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        // Async reset while a result is held.
        sendGroup(9, 9, 9, 9, 36);
        resetAsync();
        sendGroup(6, 7, 8, 9, 30);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

        checkOutput("sb_drained", scoreboard.size(), 0);

        // Count = 1: each beat goes straight to Hold.
        in_valid_one  = 1'b1;
        in_data_one   = 8'd78;
        out_ready_one = 1'b0;
        checkSingle(1'b0, 0);
        in_data_one   = 8'd99;
        checkSingle(1'b1, 78);
        in_valid_one  = 1'b0;
        out_ready_one = 1'b1;
        checkSingle(1'b1, 78);
        in_valid_one  = 1'b1;
        in_data_one   = 8'd200;
        checkSingle(1'b0, 78);
        in_valid_one  = 1'b0;
        checkSingle(1'b1, 200);
        checkSingle(1'b0, 200);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
